// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: register-address width, the $0 index and the
// EX operand forward-select codes.
package mips_pkg;

   localparam int REG_AW   = 5;
   localparam int REG_ZERO = 0;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_e;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage fields in, forward selects and stall/bubble control out.
// stall_count exists only when FWD_STALL_CNT_EN is defined.
interface fwd_hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) ();

   logic [REG_AW-1:0] rs_id;
   logic [REG_AW-1:0] rt_id;
   logic [REG_AW-1:0] rd_id;
   logic              uses_rt_id;
   logic              regwrite_id;
   logic              memread_id;
   logic              flush_id;
   logic [1:0]        FA;
   logic [1:0]        FB;
   logic              stall;
   logic              pc_write;
   logic              ifid_write;
   logic              idex_bubble;
`ifdef FWD_STALL_CNT_EN
   logic [CNT_W-1:0]  stall_count;
`endif

   // master: the pipeline datapath; slave: the forwarding/hazard unit
   modport master (
      output rs_id, rt_id, rd_id, uses_rt_id, regwrite_id, memread_id, flush_id,
      input  FA, FB, stall, pc_write, ifid_write, idex_bubble
`ifdef FWD_STALL_CNT_EN
      , input stall_count
`endif
   );

   modport slave (
      input  rs_id, rt_id, rd_id, uses_rt_id, regwrite_id, memread_id, flush_id,
      output FA, FB, stall, pc_write, ifid_write, idex_bubble
`ifdef FWD_STALL_CNT_EN
      , output stall_count
`endif
   );

endinterface

// File: rtl/fwd_sel.sv
// Forward-select for one EX source register: MEM result beats WB data, $0 never forwards.
module fwd_sel
   import mips_pkg::*;
#(
   parameter int AW = mips_pkg::REG_AW
) (
   input  logic [AW-1:0] src,
   input  logic [AW-1:0] mem_rd,
   input  logic          mem_rw,
   input  logic [AW-1:0] wb_rd,
   input  logic          wb_rw,
   output logic [1:0]    sel
);

   localparam logic [AW-1:0] RZ = AW'(REG_ZERO);

   always_comb begin
      sel = FWD_REG;
      if (mem_rw && (mem_rd != RZ) && (mem_rd == src)) begin
         sel = FWD_MEM;
      end else if (wb_rw && (wb_rd != RZ) && (wb_rd == src)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard unit tracking EX/MEM/WB register fields beside ID/EX.
// Define FWD_STALL_CNT_EN to add the stall_count output and its counter.
module fwd_hazard_ctrl #(
   parameter int REG_AW = mips_pkg::REG_AW,
   parameter int CNT_W  = 32
) (
   input logic              clk,
   input logic              rst,
   fwd_hazard_ctrl_if.slave bus
);

   localparam logic [REG_AW-1:0] RZ = REG_AW'(mips_pkg::REG_ZERO);

   logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
   logic              ex_rw, ex_mr;
   logic [REG_AW-1:0] mem_rd;
   logic              mem_rw;
   logic [REG_AW-1:0] wb_rd;
   logic              wb_rw;

   logic              stall;
   logic              bubble;
   logic [1:0]        fa, fb;

   // Load-use check uses only registered EX state plus ID fields, so no datapath loop
   always_comb begin
      stall = ex_mr && (ex_rd != RZ) &&
              ((ex_rd == bus.rs_id) || (bus.uses_rt_id && (ex_rd == bus.rt_id)));
   end

   assign bubble          = stall | bus.flush_id;
   assign bus.stall       = stall;
   assign bus.pc_write    = ~stall;
   assign bus.ifid_write  = ~stall;
   assign bus.idex_bubble = bubble;
   assign bus.FA          = fa;
   assign bus.FB          = fb;

   // ID -> EX -> MEM -> WB shadow shift; a bubble enters EX with every field zero
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_rs  <= '0;
         ex_rt  <= '0;
         ex_rd  <= '0;
         ex_rw  <= 1'b0;
         ex_mr  <= 1'b0;
         mem_rd <= '0;
         mem_rw <= 1'b0;
         wb_rd  <= '0;
         wb_rw  <= 1'b0;
      end else begin
         wb_rd  <= mem_rd;
         wb_rw  <= mem_rw;
         mem_rd <= ex_rd;
         mem_rw <= ex_rw;
         if (bubble) begin
            ex_rs <= '0;
            ex_rt <= '0;
            ex_rd <= '0;
            ex_rw <= 1'b0;
            ex_mr <= 1'b0;
         end else begin
            ex_rs <= bus.rs_id;
            ex_rt <= bus.rt_id;
            ex_rd <= bus.rd_id;
            ex_rw <= bus.regwrite_id;
            ex_mr <= bus.memread_id;
         end
      end
   end

   fwd_sel #(.AW(REG_AW)) u_fwd_a (
      .src    (ex_rs),
      .mem_rd (mem_rd),
      .mem_rw (mem_rw),
      .wb_rd  (wb_rd),
      .wb_rw  (wb_rw),
      .sel    (fa)
   );

   fwd_sel #(.AW(REG_AW)) u_fwd_b (
      .src    (ex_rt),
      .mem_rd (mem_rd),
      .mem_rw (mem_rw),
      .wb_rd  (wb_rd),
      .wb_rw  (wb_rw),
      .sel    (fb)
   );

`ifdef FWD_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign bus.stall_count = stall_cnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed MIPS sequences then random traffic against an
// in-flight instruction list model. Define FWD_STALL_CNT_EN to also check stall_count.
module tb_fwd_hazard_ctrl;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   fwd_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) bus ();

   fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
   } ins_t;

   // Instructions past ID, youngest first: index 0 in EX, 1 in MEM, 2 in WB
   ins_t        inflight[$];
   ins_t        cur;
   logic        cur_use, cur_flush, cur_rst;
   logic        exp_stall;
   int unsigned exp_cnt;
   int          checks = 0;
   int          errors = 0;

   logic [4:0]  r_rs, r_rt, r_rd;
   logic        r_use, r_wr, r_ld, r_fl, r_rst, hold;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Nearest older writer of src among the instructions in MEM and WB supplies the operand
   function automatic logic [1:0] fwd_expect(input logic [4:0] src);
      if (src == 5'd0) return 2'b00;
      for (int age = 1; age <= 2; age++) begin
         if (inflight[age].wr && inflight[age].rd == src)
            return (age == 1) ? 2'b10 : 2'b01;
      end
      return 2'b00;
   endfunction

   function automatic logic stall_expect();
      ins_t ex;
      ex = inflight[0];
      return ex.ld && (ex.rd != 5'd0) &&
             ((ex.rd == cur.rs) || (cur_use && ex.rd == cur.rt));
   endfunction

   task automatic drive(input logic r, input logic [4:0] i_rs, input logic [4:0] i_rt,
                        input logic [4:0] i_rd, input logic i_use, input logic i_wr,
                        input logic i_ld, input logic i_fl);
      @(negedge clk);
      rst             = r;
      bus.rs_id       = i_rs;
      bus.rt_id       = i_rt;
      bus.rd_id       = i_rd;
      bus.uses_rt_id  = i_use;
      bus.regwrite_id = i_wr;
      bus.memread_id  = i_ld;
      bus.flush_id    = i_fl;
      cur       = '{rs: i_rs, rt: i_rt, rd: i_rd, wr: i_wr, ld: i_ld};
      cur_use   = i_use;
      cur_flush = i_fl;
      cur_rst   = r;
      #1;
      exp_stall = stall_expect();
      if (!r) begin
         check("stall",       32'(bus.stall),       32'(exp_stall));
         check("pc_write",    32'(bus.pc_write),    32'(!exp_stall));
         check("ifid_write",  32'(bus.ifid_write),  32'(!exp_stall));
         check("idex_bubble", 32'(bus.idex_bubble), 32'(exp_stall | i_fl));
         check("FA",          32'(bus.FA),          32'(fwd_expect(inflight[0].rs)));
         check("FB",          32'(bus.FB),          32'(fwd_expect(inflight[0].rt)));
`ifdef FWD_STALL_CNT_EN
         check("stall_count", bus.stall_count,      exp_cnt);
`endif
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (cur_rst) begin
         inflight = {ins_t'(0), ins_t'(0), ins_t'(0)};
         exp_cnt  = 0;
      end else begin
         inflight.push_front((exp_stall || cur_flush) ? ins_t'(0) : cur);
         void'(inflight.pop_back());
         if (exp_stall) exp_cnt++;
      end
   endtask

   task automatic cyc(input logic [4:0] i_rs, input logic [4:0] i_rt, input logic [4:0] i_rd,
                      input logic i_use, input logic i_wr, input logic i_ld, input logic i_fl);
      drive(1'b0, i_rs, i_rt, i_rd, i_use, i_wr, i_ld, i_fl);
      tick();
   endtask

   task automatic nop();
      cyc(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   initial begin
      inflight = {ins_t'(0), ins_t'(0), ins_t'(0)};
      exp_cnt  = 0;
      do_reset();
      do_reset();

      // Reset state
      drive(1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
      check("rst_fa", 32'(bus.FA), 32'd0);
      check("rst_idex_bubble_follows_flush", 32'(bus.idex_bubble), 32'd1);
      tick();

      // add $3,$1,$2 ; sub $4,$3,$5 ; or $6,$3,$3
      cyc(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(5'd3, 5'd5, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 5'd3, 5'd3, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
      check("plan_sub_fa_mem", 32'(bus.FA), 32'd2);
      check("plan_sub_fb_reg", 32'(bus.FB), 32'd0);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("plan_or_fa_wb", 32'(bus.FA), 32'd1);
      check("plan_or_fb_wb", 32'(bus.FB), 32'd1);
      tick();

      // lw $2,0($1) ; add $4,$2,$5 held across one stall
      cyc(5'd1, 5'd2, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 5'd2, 5'd5, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      check("plan_lu_stall", 32'(bus.stall), 32'd1);
      check("plan_lu_pc_write", 32'(bus.pc_write), 32'd0);
      check("plan_lu_bubble", 32'(bus.idex_bubble), 32'd1);
      tick();
      drive(1'b0, 5'd2, 5'd5, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      check("plan_lu_stall_released", 32'(bus.stall), 32'd0);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("plan_lu_add_fa_wb", 32'(bus.FA), 32'd1);
      tick();

      // Two writers of $7 then a reader: MEM wins
      cyc(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(5'd3, 5'd4, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(5'd7, 5'd7, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("plan_mem_priority_fa", 32'(bus.FA), 32'd2);
      tick();

      // Writes to $0, including lw $0, never forward or stall
      cyc(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
      check("plan_lw0_no_stall", 32'(bus.stall), 32'd0);
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("plan_r0_fa", 32'(bus.FA), 32'd0);
      check("plan_r0_fb", 32'(bus.FB), 32'd0);
      tick();
      nop(); nop();

      // Flushed add $3 leaves a bubble; a later reader of $3 gets register data
      cyc(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
      cyc(5'd3, 5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("plan_flush_fa", 32'(bus.FA), 32'd0);
      check("plan_flush_fb", 32'(bus.FB), 32'd0);
      tick();

      // Reset while a load sits in EX
      cyc(5'd1, 5'd2, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 5'd2, 5'd5, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 5'd2, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      check("plan_rst_stall", 32'(bus.stall), 32'd0);
      check("plan_rst_fa", 32'(bus.FA), 32'd0);
      tick();

      // Three load-use pairs from a clean reset
      do_reset();
      for (int k = 0; k < 3; k++) begin
         cyc(5'd1, 5'd0, 5'd10, 1'b0, 1'b1, 1'b1, 1'b0);
         cyc(5'd10, 5'd0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0);
         cyc(5'd10, 5'd0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0);
      end
`ifdef FWD_STALL_CNT_EN
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("plan_three_stalls", bus.stall_count, 32'd3);
      tick();
`endif

      // Random traffic; a stalled ID instruction is re-presented like the held IF/ID
      hold = 1'b0;
      for (int n = 0; n < 600; n++) begin
         r_rst = ($urandom_range(0, 99) < 3);
         r_fl  = ($urandom_range(0, 9) == 0);
         if (!hold) begin
            r_rs  = 5'($urandom_range(0, 7));
            r_rt  = 5'($urandom_range(0, 7));
            r_rd  = 5'($urandom_range(0, 7));
            r_use = 1'($urandom_range(0, 1));
            r_ld  = ($urandom_range(0, 2) == 0);
            r_wr  = r_ld | ($urandom_range(0, 3) != 0);
         end
         drive(r_rst, r_rs, r_rt, r_rd, r_use, r_wr, r_ld, r_fl);
         hold = exp_stall && !r_rst && !r_fl;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and hazard control unit for the 5-stage MIPS-32 pipeline. It keeps its own shadow copy of the register-address and control fields for the EX, MEM and WB stages. From these it drives the 2-bit FA/FB select codes consumed by the EX-stage operand forwarding muxes, detects load-use hazards, and issues stall and bubble control to the PC, IF/ID and ID/EX registers. It sits beside the ID/EX boundary and is clocked in lockstep with the datapath pipeline registers.

## Interface
Parameters:
- `REG_AW`, 5, register-address width.
- `CNT_W`, 32, stall-counter width (used only with `FWD_STALL_CNT_EN`).

Ports (name, direction, width, meaning):
- `clk` input 1: pipeline clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rs_id` input REG_AW: rs field of the instruction in ID.
- `rt_id` input REG_AW: rt field of the instruction in ID.
- `rd_id` input REG_AW: write-destination of the ID instruction, after the RegDst mux.
- `uses_rt_id` input 1: ID instruction reads rt (R-type, store, beq/bne).
- `regwrite_id` input 1: ID instruction writes the register file.
- `memread_id` input 1: ID instruction is a load.
- `flush_id` input 1: squash the ID instruction (taken branch or jump).
- `FA` output 2: operand-A select for EX. 00 = register data, 01 = WB write data, 10 = MEM ALU result.
- `FB` output 2: operand-B select for EX, same encoding as `FA`.
- `stall` output 1: load-use stall is active this cycle.
- `pc_write` output 1: PC enable, equal to `~stall`.
- `ifid_write` output 1: IF/ID enable, equal to `~stall`.
- `idex_bubble` output 1: ID/EX loads a NOP, equal to `stall | flush_id`.
- `stall_count` output CNT_W: number of stall cycles (present only with `FWD_STALL_CNT_EN`).

## Operation
- Shadow registers:
  - EX stage: `ex_rs`, `ex_rt`, `ex_rd`, `ex_rw`, `ex_mr`.
  - MEM stage: `mem_rd`, `mem_rw`.
  - WB stage: `wb_rd`, `wb_rw`.
- Each rising edge:
  - MEM→WB and EX→MEM always shift.
  - ID→EX loads the ID fields, or loads a bubble (all fields 0) when `idex_bubble` is 1.
- `FA` is combinational from the shadow state:
  - 10 if `mem_rw && mem_rd!=0 && mem_rd==ex_rs`.
  - Otherwise 01 if `wb_rw && wb_rd!=0 && wb_rd==ex_rs`.
  - Otherwise 00.
- `FB` uses the same rules with `ex_rt`.
- MEM has priority over WB when both match. Register $0 is never forwarded.
- `stall` = `ex_mr && ex_rd!=0 && (ex_rd==rs_id || (uses_rt_id && ex_rd==rt_id))`.
- `stall` is held for exactly one cycle per load-use pair. After the bubble the load sits in MEM and is not a load-use source, so `stall` deasserts and the dependent instruction is then forwarded from WB (01).
- Simultaneous `stall` and `flush_id`: flush wins for the ID instruction, which is still bubbled. `pc_write` and `ifid_write` still follow `~stall`, because the branch redirect owns the PC.
- States per stage are implicit. An entry is valid when its `rw` bit is 1; a bubble has `rw=0` and `rd=0`.

## Timing
- Reset, at the first rising edge with `rst=1`:
  - All shadow fields are cleared.
  - `FA=FB=00`, `stall=0`, `pc_write=ifid_write=1`, `idex_bubble=flush_id`, `stall_count=0`.
- Forward selects are valid in the same cycle the instruction occupies EX. Latency from the ID inputs to the EX-stage `FA`/`FB` is 1 clock.
- `stall` responds combinationally to the ID inputs in the same cycle. It depends only on registered `ex_*` state plus the ID inputs, so there is no combinational loop through the datapath.
- Reset asserted mid-operation clears all in-flight shadow entries on that edge. No forwarding from pre-reset instructions is allowed afterwards.

## Configuration
- `FWD_STALL_CNT_EN` defined:
  - `stall_count` exists. It increments by 1 on every rising edge where `stall=1` and `rst=0`, and wraps modulo 2^CNT_W.
  - It is cleared by `rst`.
- `FWD_STALL_CNT_EN` undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package/header `mips_pkg`:
  - Forward-select constants `FWD_REG=2'b00`, `FWD_WB=2'b01`, `FWD_MEM=2'b10`.
  - `REG_AW` and the $0 constant.
- One sub-module, `fwd_sel`: pure combinational compare of one EX source register against MEM/WB destinations, returning a 2-bit select. It is instantiated twice, once for FA and once for FB.
- Top level holds the shadow registers, stall logic and counter.

## Test plan
- `add $3,$1,$2` then `sub $4,$3,$5` → in the sub's EX cycle `FA=10`, `FB=00`. Next instruction `or $6,$3,$3` → `FA=FB=01`.
- `lw $2,0($1)` then `add $4,$2,$5` → `stall=1` for one cycle, `pc_write=0`, `idex_bubble=1`. Then `stall=0`, and the add's EX has `FA=01`.
- Both MEM and WB write $7, EX reads $7 → `FA=10` (MEM priority).
- Write to $0 followed by a read of $0 → `FA=FB=00`, `stall=0`, including after `lw $0`.
- `flush_id=1` on `add $3,...` → the next EX entry is a bubble, and a following reader of $3 gets 00.
- `rst` asserted while a load is in EX → next cycle `stall=0`, `FA=FB=00`. With `FWD_STALL_CNT_EN`, three load-use pairs give `stall_count=3`.
